// File: rtl/cv32e40x_param_fifo.sv
// Width-parametrised valid/ready FIFO with optional fall-through, almost-full/empty
// thresholds, an occupancy high-watermark and flush / flush-but-first controls.
module cv32e40x_param_fifo #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 4,
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned AF_THRESH    = DEPTH - 1,
    parameter int unsigned AE_THRESH    = 1,
    parameter bit          RESET_MEM    = 1'b1,
    localparam int unsigned ADDR_W      = $clog2(DEPTH),
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              flush_but_first_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [CNT_W-1:0]  hwm_o,
    input  logic              hwm_clr_i
);

    if (DEPTH < 2) begin : g_depth_chk
        $error("cv32e40x_param_fifo: DEPTH must be at least 2");
    end
    if (AF_THRESH > DEPTH) begin : g_af_chk
        $error("cv32e40x_param_fifo: AF_THRESH must not exceed DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_ae_chk
        $error("cv32e40x_param_fifo: AE_THRESH must be below DEPTH");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_n;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [CNT_W-1:0]  hwm_q, hwm_n;
    logic              empty_q, full_q;
    logic              flushing;
    logic              push, pop, bypass, write_en;

    // Pointers wrap explicitly so a non-power-of-two DEPTH works.
    function automatic logic [ADDR_W-1:0] inc_ptr(input logic [ADDR_W-1:0] ptr);
        return (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
    endfunction

    assign empty_q  = (cnt_q == '0);
    assign full_q   = (cnt_q == CNT_W'(DEPTH));
    assign flushing = flush_i | flush_but_first_i;

    assign in_ready_o  = ~full_q & ~flushing;
    assign out_valid_o = (~empty_q | (FALL_THROUGH & in_valid_i)) & ~flushing;
    assign out_data_o  = ~empty_q     ? mem_q[rd_ptr_q] :
                         FALL_THROUGH ? in_data_i       : '0;

    assign push     = in_valid_i & in_ready_o;
    assign pop      = out_valid_o & out_ready_i;
    assign bypass   = FALL_THROUGH & empty_q & push & pop;
    assign write_en = push & ~bypass;

    assign cnt_o          = cnt_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = (cnt_q >= CNT_W'(AF_THRESH));
    assign almost_empty_o = (cnt_q <= CNT_W'(AE_THRESH));
    assign hwm_o          = hwm_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        rd_ptr_n = rd_ptr_q;
        wr_ptr_n = wr_ptr_q;
        cnt_n    = cnt_q;
        if (flush_i) begin
            rd_ptr_n = '0;
            wr_ptr_n = '0;
            cnt_n    = '0;
        end else if (flush_but_first_i) begin
            if (!empty_q) begin
                wr_ptr_n = inc_ptr(rd_ptr_q);
                cnt_n    = CNT_W'(1);
            end
        end else if (!bypass) begin
            if (push) wr_ptr_n = inc_ptr(wr_ptr_q);
            if (pop)  rd_ptr_n = inc_ptr(rd_ptr_q);
            if (push && !pop)      cnt_n = cnt_q + CNT_W'(1);
            else if (pop && !push) cnt_n = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        hwm_n = hwm_q;
        if (hwm_clr_i)          hwm_n = cnt_n;
        else if (cnt_n > hwm_q) hwm_n = cnt_n;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            hwm_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_n;
            wr_ptr_q <= wr_ptr_n;
            cnt_q    <= cnt_n;
            hwm_q    <= hwm_n;
        end
    end

    if (RESET_MEM) begin : g_mem_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            end else if (write_en) begin
                mem_q[wr_ptr_q] <= in_data_i;
            end
        end
    end else begin : g_mem_norst
        // NOTE: without a reset the array can map onto plain RAM; the empty gating on
        // out_data_o keeps unwritten contents from ever reaching the output.
        always_ff @(posedge clk_i) begin
            if (write_en) mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CNT_W'(DEPTH));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && full_q));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && empty_q && !FALL_THROUGH));
    a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i) |=> $stable(out_data_o));

endmodule

// File: tb/tb_cv32e40x_param_fifo.sv
// Directed bench for cv32e40x_param_fifo: DEPTH=3, DATA_W=8, AF=2, AE=1, with a
// second fall-through instance for the bypass cases.
module tb_cv32e40x_param_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       flush = 1'b0, fbf = 1'b0, hwm_clr = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, out_valid, full, empty, af, ae;
    logic [7:0] out_data;
    logic [1:0] cnt, hwm;

    logic       ft_in_valid = 1'b0, ft_out_ready = 1'b0;
    logic [7:0] ft_in_data = '0;
    logic       ft_in_ready, ft_out_valid, ft_full, ft_empty, ft_af, ft_ae;
    logic [7:0] ft_out_data;
    logic [1:0] ft_cnt, ft_hwm;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cv32e40x_param_fifo #(
        .DATA_W(8), .DEPTH(3), .FALL_THROUGH(1'b0), .AF_THRESH(2), .AE_THRESH(1), .RESET_MEM(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .flush_but_first_i(fbf),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .cnt_o(cnt), .full_o(full), .empty_o(empty), .almost_full_o(af),
        .almost_empty_o(ae), .hwm_o(hwm), .hwm_clr_i(hwm_clr)
    );

    cv32e40x_param_fifo #(
        .DATA_W(8), .DEPTH(3), .FALL_THROUGH(1'b1), .AF_THRESH(2), .AE_THRESH(1), .RESET_MEM(1'b1)
    ) dut_ft (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .flush_but_first_i(1'b0),
        .in_valid_i(ft_in_valid), .in_ready_o(ft_in_ready), .in_data_i(ft_in_data),
        .out_valid_o(ft_out_valid), .out_ready_i(ft_out_ready), .out_data_o(ft_out_data),
        .cnt_o(ft_cnt), .full_o(ft_full), .empty_o(ft_empty), .almost_full_o(ft_af),
        .almost_empty_o(ft_ae), .hwm_o(ft_hwm), .hwm_clr_i(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flags follow from occupancy: full at 3, empty at 0, almost_full >= 2, almost_empty <= 1.
    task automatic check_state(input string tag, input int exp_cnt);
        check({tag, ".cnt"},   32'(cnt), 32'(exp_cnt));
        check({tag, ".full"},  32'(full), 32'(exp_cnt == 3));
        check({tag, ".empty"}, 32'(empty), 32'(exp_cnt == 0));
        check({tag, ".af"},    32'(af), 32'(exp_cnt >= 2));
        check({tag, ".ae"},    32'(ae), 32'(exp_cnt <= 1));
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".in_ready"},  32'(in_ready), 32'd1);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".out_data"},  32'(out_data), 32'd0);
        check({tag, ".hwm"},       32'(hwm), 32'd0);
        check_state(tag, 0);
        check({tag, ".ft_cnt"},    32'(ft_cnt), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        #7;
        check_reset("reset");
        #1 rst_n = 1'b1;
        tick();

        // 1: fill to full, no ready-through, drain in order
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hA1; tick(); check_state("t1_a1", 1);
        in_data = 8'hA2; tick(); check_state("t1_a2", 2);
        in_data = 8'hA3; tick(); check_state("t1_a3", 3);
        check("t1_in_ready_full", 32'(in_ready), 32'd0);
        check("t1_hwm", 32'(hwm), 32'd3);
        check("t1_head", 32'(out_data), 32'hA1);
        in_data = 8'hA4; out_ready = 1'b1; #1;
        check("t1_no_ready_through", 32'(in_ready), 32'd0);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        tick(); check_state("t1_pop1", 2);
        in_valid = 1'b0; #1;
        check("t1_data2", 32'(out_data), 32'hA2);
        tick(); check("t1_data3", 32'(out_data), 32'hA3);
        tick(); check_state("t1_drained", 0);
        check("t1_out_valid_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // 2: stream 10 words with push and pop every cycle, pointers wrap
        in_valid = 1'b1; in_data = 8'h10; tick();
        check_state("t2_prime", 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_data = 8'h10 + 8'(i); #1;
            check($sformatf("t2_data%0d", i), 32'(out_data), 32'(8'h10 + 8'(i - 1)));
            tick();
            check($sformatf("t2_cnt%0d", i), 32'(cnt), 32'd1);
        end
        in_valid = 1'b0; #1;
        check("t2_last", 32'(out_data), 32'h1A);
        tick(); check_state("t2_drained", 0);
        out_ready = 1'b0;

        // 3: fall-through bypass, then normal write when not ready
        ft_in_valid = 1'b1; ft_in_data = 8'h5C; ft_out_ready = 1'b1; #1;
        check("t3_ft_valid", 32'(ft_out_valid), 32'd1);
        check("t3_ft_data", 32'(ft_out_data), 32'h5C);
        tick();
        check("t3_ft_cnt_bypass", 32'(ft_cnt), 32'd0);
        check("t3_ft_empty", 32'(ft_empty), 32'd1);
        ft_out_ready = 1'b0; tick();
        check("t3_ft_cnt_write", 32'(ft_cnt), 32'd1);
        check("t3_ft_data_held", 32'(ft_out_data), 32'h5C);
        ft_in_valid = 1'b0; ft_out_ready = 1'b1; tick();
        check("t3_ft_cnt_pop", 32'(ft_cnt), 32'd0);
        check("t3_ft_hwm", 32'(ft_hwm), 32'd1);
        ft_out_ready = 1'b0;

        // 4: flush-but-first keeps the head, then appends
        in_valid = 1'b1;
        in_data = 8'hB1; tick();
        in_data = 8'hB2; tick();
        in_data = 8'hB3; tick();
        check_state("t4_full", 3);
        in_data = 8'hEE; fbf = 1'b1; out_ready = 1'b1; #1;
        check("t4_fbf_out_valid", 32'(out_valid), 32'd0);
        check("t4_fbf_in_ready", 32'(in_ready), 32'd0);
        tick();
        fbf = 1'b0; out_ready = 1'b0; in_valid = 1'b0; #1;
        check_state("t4_after_fbf", 1);
        check("t4_head_b1", 32'(out_data), 32'hB1);
        in_valid = 1'b1; in_data = 8'hC1; tick();
        check_state("t4_c1", 2);
        in_valid = 1'b0; out_ready = 1'b1; #1;
        check("t4_pop_b1", 32'(out_data), 32'hB1);
        tick(); check("t4_pop_c1", 32'(out_data), 32'hC1);
        tick(); check_state("t4_drained", 0);
        out_ready = 1'b0;

        // 5: flush has priority, keeps hwm; hwm_clr reloads with occupancy
        in_valid = 1'b1;
        in_data = 8'hD1; tick();
        in_data = 8'hD2; tick();
        in_valid = 1'b0; flush = 1'b1; fbf = 1'b1; tick();
        flush = 1'b0; fbf = 1'b0; #1;
        check_state("t5_flushed", 0);
        check("t5_hwm_kept", 32'(hwm), 32'd3);
        hwm_clr = 1'b1; tick();
        hwm_clr = 1'b0; #1;
        check("t5_hwm_cleared", 32'(hwm), 32'd0);

        // 6: asynchronous reset mid-stream, then resume
        in_valid = 1'b1;
        in_data = 8'hE1; tick();
        in_data = 8'hE2; tick();
        check_state("t6_pre", 2);
        in_valid = 1'b0; #2;
        rst_n = 1'b0; #1;
        check_reset("t6_async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 8'hF1; tick();
        check_state("t6_resume", 1);
        in_valid = 1'b0; out_ready = 1'b1; #1;
        check("t6_data", 32'(out_data), 32'hF1);
        tick(); check_state("t6_drained", 0);
        check("t6_hwm", 32'(hwm), 32'd1);
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
